mul_issue_ctrl: RTL
===================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter: DEST_W, default 5, width of the destination-register tag carried with each operation.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream (EX) presents a multiply op.
REQ-005 in_ready  output  1  block accepts op this cycle.
REQ-006 in_op  input  2  00 MUL (low word), 01 MULH (signed high), 10 MULHU (unsigned high), 11 treated as MUL.
REQ-007 in_src1 / in_src2  input  32 each  multiplicand / multiplier.
REQ-008 in_dest  input  DEST_W  destination tag.
REQ-009 flush  input  1  kill in-flight op (exception/branch cancel).
REQ-010 mul_signed  output  1  to booth multiplier signed select.
REQ-011 mul_x / mul_y  output  32 each  operands to booth multiplier.
REQ-012 mul_result  input  64  registered product from booth multiplier (1-cycle latency from operands).
REQ-013 out_valid  output  1  result available to downstream (MEM).
REQ-014 out_ready  input  1  downstream consumes result.
REQ-015 out_result / out_dest  output  32 / DEST_W  selected product word and tag.
REQ-016 busy  output  1  high when state is not IDLE; used for hazard stall.
REQ-017 perf_mul_cnt  output  32  completed-op counter (see Configuration).

Function
REQ-018 FSM states IDLE, CALC, DONE, held in a register, encoded one-hot.
REQ-019 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready), and SHALL be 0 whenever flush=1.
REQ-020 Accept (in_valid & in_ready & ~flush) SHALL register src1, src2, op, dest and move to CALC.
REQ-021 mul_x/mul_y/mul_signed SHALL be driven from the registered operands only, never combinationally from in_*; mul_signed=1 only for op 01.
REQ-022 CALC SHALL last exactly one cycle, then go to DONE unconditionally.
REQ-023 Latency: op accepted at edge T -> out_valid=1 from edge T+2; out_result=mul_result[31:0] for op 00/11, mul_result[63:32] for op 01/10.
REQ-024 In DONE, out_valid=1 and out_result/out_dest SHALL hold stable until out_ready=1.
REQ-025 DONE & out_ready & accepted new op -> CALC (back-to-back, one result per 2 cycles); DONE & out_ready & no accept -> IDLE.
REQ-026 flush=1 in any state -> IDLE at next edge; out_valid=0 from that edge; flush has priority over accept and over out_ready completion (a flushed DONE op is not counted).
REQ-027 Registered operands SHALL stay unchanged outside an accept, so mul_result stays stable throughout DONE.
REQ-028 out_valid SHALL be 0 in IDLE and CALC; outputs SHALL be X-free after reset.

Reset
REQ-029 reset=1 SHALL immediately force state=IDLE, out_valid=0, busy=0, in_ready=1 (modulo flush), registered operands/op/dest=0, perf_mul_cnt=0.
REQ-030 reset asserted mid-operation (CALC or DONE) SHALL discard the op with no output handshake.

Configuration
REQ-031 Macro MUL_PERF_CNT_EN: when defined, perf_mul_cnt increments by 1 on every out_valid & out_ready & ~flush, wrapping 0xFFFFFFFF -> 0; when undefined, perf_mul_cnt is tied to 0 and no counter flops exist. Port present in both builds.

Verification
REQ-032 MULH 0xFFFFFFFF x 0xFFFFFFFF, out_ready=1 -> out_valid at T+2, out_result=0x00000000.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> out_result=0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-034 MULH 0x80000000 x 0x80000000, out_ready=0 for 5 cycles then 1 -> out_result=0x40000000 stable all 5 cycles, in_ready=0 while held.
REQ-035 Back-to-back MUL 0x00010000 x 0x00010000 then MULHU same, out_ready=1 -> results 0x00000000 then 0x00000001 on consecutive DONE cycles 2 apart, dest tags preserved.
REQ-036 flush in CALC -> no out_valid; flush with in_valid in DONE -> IDLE, op not accepted; with MUL_PERF_CNT_EN, counter unchanged by flushed ops and equals completed count.
REQ-037 reset pulse in DONE -> out_valid=0 and busy=0 without waiting for clk.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/handshake controller that sits between the EX stage
// and an external booth multiplier with a one-cycle registered product.
// It captures one multiply op, presents the captured operands to the
// multiplier, and returns the requested product word with its destination tag.
// Optional feature macro: MUL_PERF_CNT_EN adds a completed-op counter on
// perf_mul_cnt. When the macro is undefined, that port is tied to zero.
module mul_issue_ctrl #(
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [31:0]       in_src1,
  input  logic [31:0]       in_src2,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              flush,
  output logic              mul_signed,
  output logic [31:0]       mul_x,
  output logic [31:0]       mul_y,
  input  logic [63:0]       mul_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              busy,
  output logic [31:0]       perf_mul_cnt
);

  localparam logic [1:0] OP_MULH  = 2'b01;
  localparam logic [1:0] OP_MULHU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_CALC = 3'b010,
    S_DONE = 3'b100
  } state_e;

  state_e              state_q;
  logic                out_valid_q;
  logic [31:0]         src1_q, src1_d;
  logic [31:0]         src2_q, src2_d;
  logic [1:0]          op_q, op_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                accept;

  // A new op may enter when idle, or when the held result leaves this cycle.
  // Flush blocks entry so a cancelled cycle never loads operands.
  assign in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Sequence IDLE -> CALC -> DONE. Flush wins over both accept and completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) state_q <= S_CALC;
          out_valid_q <= 1'b0;
        end
        S_CALC: begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= accept ? S_CALC : S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Operands only change on accept, which keeps the multiplier product steady through DONE.
  always_comb begin
    src1_d = src1_q;
    src2_d = src2_q;
    op_d   = op_q;
    dest_d = dest_q;
    if (accept) begin
      src1_d = in_src1;
      src2_d = in_src2;
      op_d   = in_op;
      dest_d = in_dest;
    end
  end

  // Operand/tag capture register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src1_q <= '0;
      src2_q <= '0;
      op_q   <= '0;
      dest_q <= '0;
    end else begin
      src1_q <= src1_d;
      src2_q <= src2_d;
      op_q   <= op_d;
      dest_q <= dest_d;
    end
  end

  assign mul_x      = src1_q;
  assign mul_y      = src2_q;
  assign mul_signed = (op_q == OP_MULH);
  assign out_valid  = out_valid_q;
  assign out_dest   = dest_q;
  assign busy       = (state_q != S_IDLE);

  // High-word ops take the upper half of the product. MUL and the spare encoding take the lower half.
  always_comb begin
    out_result = mul_result[31:0];
    if ((op_q == OP_MULH) || (op_q == OP_MULHU)) out_result = mul_result[63:32];
  end

`ifdef MUL_PERF_CNT_EN
  logic        complete;
  logic [31:0] cnt_q, cnt_d;

  // A result counts only when it is really handed off. A flushed DONE is not counted.
  assign complete = out_valid_q & out_ready & ~flush;

  // Next count, wrapping naturally at 32 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (complete) cnt_d = cnt_q + 32'd1;
  end

  // Completed-op counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign perf_mul_cnt = cnt_q;
`else
  assign perf_mul_cnt = '0;
`endif

endmodule
